ifetch: RTL and testbench

Instruction fetch stage, directly upstream of the decoder. It generates sequential PCs and issues requests to the instruction memory over a valid/grant handshake. Returned instructions land in a 2-entry buffer and are presented to decode as `o_ir_instr`/`o_ir_pc` with valid/ready. A redirect from the branch/jump unit flushes the buffer, discards in-flight responses and restarts fetch at the new PC.

---
 rtl/ifetch_if.sv | 29 ++
 rtl/ifetch.sv | 110 +++++++++++
 tb/tb_ifetch.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - fetch-stage bus bundle: imem request/response, redirect, decode handoff
interface ifetch_if;
  // instruction memory request / response
  logic        o_imem_req;
  logic        i_imem_gnt;
  logic [31:0] o_imem_addr;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  // redirect from branch/jump unit
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  // handoff to decode
  logic        o_ir_valid;
  logic        i_ir_ready;
  logic [31:0] o_ir_instr;
  logic [31:0] o_ir_pc;

  // fetch-stage view
  modport master (
    output o_imem_req, o_imem_addr, o_ir_valid, o_ir_instr, o_ir_pc,
    input  i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_redirect, i_redirect_pc, i_ir_ready
  );

  // environment view (memory, branch unit, decode)
  modport slave (
    input  o_imem_req, o_imem_addr, o_ir_valid, o_ir_instr, o_ir_pc,
    output i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_redirect, i_redirect_pc, i_ir_ready
  );
endinterface

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch: sequential PC, credit-limited imem requests, 2-entry buffer
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic       i_clk,
  input logic       i_rst_n,
  ifetch_if.master  bus
);

  // fetch / response PCs
  logic [31:0] fpc;
  logic [31:0] rpc;

  // outstanding requests, responses to discard, buffer occupancy
  logic [1:0]  inflight;
  logic [1:0]  drop;
  logic [1:0]  occ;

  // 2-entry buffer of {instr, pc}
  logic [31:0] buf_instr [2];
  logic [31:0] buf_pc    [2];
  logic        wr_ptr;
  logic        rd_ptr;

  logic        pop;
  logic        req;
  logic        grant;
  logic        push;
  logic [2:0]  credit;
  logic [31:0] new_pc;

  // handshake decode: a slot is free when buffered + outstanding < 2,
  // or exactly 2 while decode takes one this cycle (keeps 1 instr/cycle)
  always_comb begin
    credit = {1'b0, occ} + {1'b0, inflight};
    pop    = (occ != 2'd0) & bus.i_ir_ready;
    req    = i_rst_n & ~bus.i_redirect &
             ((credit < 3'd2) | ((credit == 3'd2) & pop));
    grant  = req & bus.i_imem_gnt;
    push   = bus.i_imem_rvalid & ~bus.i_redirect & (drop == 2'd0);
    new_pc = bus.i_redirect_pc & 32'hFFFF_FFFC;
  end

  assign bus.o_imem_req  = req;
  assign bus.o_imem_addr = fpc;
  assign bus.o_ir_valid  = (occ != 2'd0);
  assign bus.o_ir_instr  = buf_instr[rd_ptr];
  assign bus.o_ir_pc     = buf_pc[rd_ptr];

  // PC, credit and drop bookkeeping; redirect overrides everything else
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fpc      <= RESET_PC;
      rpc      <= RESET_PC;
      inflight <= 2'd0;
      drop     <= 2'd0;
      occ      <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else if (bus.i_redirect) begin
      // every still-outstanding response belongs to the old stream;
      // one arriving right now is discarded here, so it is not counted
      fpc      <= new_pc;
      rpc      <= new_pc;
      inflight <= inflight - {1'b0, bus.i_imem_rvalid};
      drop     <= inflight - {1'b0, bus.i_imem_rvalid};
      occ      <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      if (grant) begin
        fpc <= fpc + 32'd4;
      end
      if (push) begin
        rpc    <= rpc + 32'd4;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      inflight <= inflight + {1'b0, grant} - {1'b0, bus.i_imem_rvalid};
      if (bus.i_imem_rvalid && (drop != 2'd0)) begin
        drop <= drop - 2'd1;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  // buffer storage; cleared on reset so the decode outputs start at zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_instr[0] <= 32'd0;
      buf_instr[1] <= 32'd0;
      buf_pc[0]    <= 32'd0;
      buf_pc[1]    <= 32'd0;
    end else if (push) begin
      buf_instr[wr_ptr] <= bus.i_imem_rdata;
      buf_pc[wr_ptr]    <= rpc;
    end
  end

  // the credit rule must make a push into a full buffer impossible
  a_no_push_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(push && (occ == 2'd2)));

  // counters stay inside their legal ranges
  a_ranges: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (inflight <= 2'd2) && (occ <= 2'd2) && (drop <= inflight));

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - randomized self-checking bench for ifetch against a stream-level model
module tb_ifetch;

  localparam logic [31:0] KEY = 32'h1234_5678;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ifetch_if bus ();
  ifetch_if wbus ();

  ifetch u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  ifetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (wbus)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // model: next fetch address, PC expected at the decode head,
  // and counts of outstanding, to-be-dropped and buffered instructions
  logic [31:0] m_fpc;
  logic [31:0] m_exp;
  int          m_inflight;
  int          m_drop;
  int          m_occ;

  // memory: in-order queue of granted addresses and their due cycles
  logic [31:0] mq_addr [$];
  int          mq_due  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_fpc      = 32'h8000_0000;
    m_exp      = 32'h8000_0000;
    m_inflight = 0;
    m_drop     = 0;
    m_occ      = 0;
    mq_addr.delete();
    mq_due.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n              = 1'b0;
    bus.i_imem_gnt     = 1'b0;
    bus.i_ir_ready     = 1'b0;
    bus.i_redirect     = 1'b0;
    bus.i_redirect_pc  = 32'd0;
    bus.i_imem_rvalid  = 1'b0;
    bus.i_imem_rdata   = 32'd0;
    #1;
    chk("rst_req",   bus.o_imem_req, 32'd0);
    chk("rst_valid", bus.o_ir_valid, 32'd0);
    chk("rst_instr", bus.o_ir_instr, 32'd0);
    chk("rst_pc",    bus.o_ir_pc,    32'd0);
    model_reset();
    cyc = 0;
  endtask

  // one cycle: drive at negedge, compare settled outputs, advance model
  task automatic step(input bit gnt, input bit rdy, input bit redir,
                      input logic [31:0] rpc, input int lat);
    bit rv;
    bit pop;
    bit req_e;
    bit grant;
    int due;
    @(negedge clk);
    rst_n = 1'b1;
    rv = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
    bus.i_imem_rvalid = rv;
    bus.i_imem_rdata  = rv ? (mq_addr[0] ^ KEY) : $urandom;
    if (rv) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    bus.i_imem_gnt    = gnt;
    bus.i_ir_ready    = rdy;
    bus.i_redirect    = redir;
    bus.i_redirect_pc = redir ? rpc : $urandom;
    #1;
    pop   = (m_occ != 0) && rdy;
    req_e = !redir && ((m_occ + m_inflight < 2) || (m_occ + m_inflight == 2 && pop));
    chk("imem_req", bus.o_imem_req, req_e);
    if (req_e) chk("imem_addr", bus.o_imem_addr, m_fpc);
    chk("ir_valid", bus.o_ir_valid, m_occ != 0);
    if (m_occ != 0) begin
      chk("ir_pc",    bus.o_ir_pc,    m_exp);
      chk("ir_instr", bus.o_ir_instr, m_exp ^ KEY);
    end
    grant = req_e && gnt;
    if (grant) begin
      due = cyc + lat;
      if (mq_due.size() > 0 && due < mq_due[$]) due = mq_due[$];
      mq_addr.push_back(bus.o_imem_addr);
      mq_due.push_back(due);
    end
    if (pop) begin
      m_exp = m_exp + 32'd4;
      m_occ--;
    end
    if (redir) begin
      m_drop     = m_inflight - int'(rv);
      m_inflight = m_inflight - int'(rv);
      m_occ      = 0;
      m_fpc      = rpc & 32'hFFFF_FFFC;
      m_exp      = m_fpc;
    end else begin
      if (grant) m_fpc = m_fpc + 32'd4;
      m_inflight = m_inflight + int'(grant) - int'(rv);
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else m_occ++;
      end
    end
    cyc++;
  endtask

  initial begin
    int n;
    wbus.i_imem_gnt    = 1'b1;
    wbus.i_ir_ready    = 1'b1;
    wbus.i_redirect    = 1'b0;
    wbus.i_redirect_pc = 32'd0;
    wbus.i_imem_rvalid = 1'b0;
    wbus.i_imem_rdata  = 32'd0;

    do_reset();

    // streaming from reset; the wrap instance fetches FFFF_FFFC then 0
    step(1, 1, 0, 0, 1);
    chk("wrap_addr0", wbus.o_imem_addr, 32'hFFFF_FFFC);
    chk("wrap_req0",  wbus.o_imem_req,  32'd1);
    step(1, 1, 0, 0, 1);
    chk("wrap_addr1", wbus.o_imem_addr, 32'h0000_0000);
    step(1, 1, 0, 0, 1);
    chk("stream_pc0",    bus.o_ir_pc,    32'h8000_0000);
    chk("stream_instr0", bus.o_ir_instr, 32'h9234_5678);
    step(1, 1, 0, 0, 1);
    chk("stream_pc1", bus.o_ir_pc, 32'h8000_0004);
    step(1, 1, 0, 0, 1);
    chk("stream_pc2", bus.o_ir_pc, 32'h8000_0008);

    // backpressure: buffer fills, requests stop, head holds
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1);
    chk("bp_req_low",  bus.o_imem_req, 32'd0);
    chk("bp_valid",    bus.o_ir_valid, 32'd1);
    chk("bp_head_pc",  bus.o_ir_pc,    32'h8000_000C);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1);

    // grant stall
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1);
    chk("stall_req", bus.o_imem_req, 32'd1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1);

    // redirect with two requests in flight, 3-cycle memory
    n = 0;
    while (m_inflight != 2 && n < 20) begin
      step(1, 1, 0, 0, 3);
      n++;
    end
    chk("reach_inflight2", m_inflight, 32'd2);
    step(1, 1, 1, 32'h0000_0102, 3);
    n = 0;
    do begin
      step(1, 1, 0, 0, 3);
      n++;
    end while (bus.o_imem_req !== 1'b1 && n < 10);
    chk("redir_first_addr", bus.o_imem_addr, 32'h0000_0100);
    n = 0;
    while (bus.o_ir_valid !== 1'b1 && n < 12) begin
      step(1, 1, 0, 0, 3);
      n++;
    end
    chk("redir_first_pc", bus.o_ir_pc, 32'h0000_0100);

    // redirect landing on a cycle with rvalid and a pop
    n = 0;
    while (!(mq_addr.size() > 0 && mq_due[0] <= cyc && m_occ > 0) && n < 20) begin
      step(1, 1, 0, 0, 1);
      n++;
    end
    chk("find_rv_pop", (mq_addr.size() > 0 && m_occ > 0), 32'd1);
    step(1, 1, 1, 32'h0000_4000, 1);
    step(1, 1, 0, 0, 1);
    chk("post_redir_empty", bus.o_ir_valid, 32'd0);
    chk("post_redir_addr",  bus.o_imem_addr, 32'h0000_4000);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 29) == 0, $urandom, $urandom_range(1, 4));
    end

    // mid-run reset and restart
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
